// File: rtl/pulse_event_coalescer.sv
// ============================================================================
// pulse_event_coalescer : counts event pulses and raises a level interrupt at
// a programmable threshold; PULSE_EVENT_COALESCER_TIMEOUT_EN adds a timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pulse_event_coalescer #(
  parameter int CNT_W = 16,
  parameter int TMO_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             pulse_i,
  input  logic [CNT_W-1:0] threshold_i,
  input  logic [TMO_W-1:0] timeout_i,
  input  logic             ack_i,
  output logic             irq_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_IRQ   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] thr;
  logic             irq_nxt;
  logic             ovf_nxt;
  logic             ovf_inc;
  logic             take;
  logic             sat;
  logic             tmo_fire;

`ifdef PULSE_EVENT_COALESCER_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMR_MAX = '1;

  logic [TMO_W-1:0] timer;
  logic [TMO_W:0]   timer_p1;

  assign timer_p1 = {1'b0, timer} + {{TMO_W{1'b0}}, 1'b1};
  assign tmo_fire = enable_i && (timeout_i != '0) && (timer_p1 >= {1'b0, timeout_i});

  // Timer only lives while the batch stays in ACCUM; any other transition clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer <= '0;
    end else if (state != ST_ACCUM || state_nxt != ST_ACCUM) begin
      timer <= '0;
    end else if (enable_i && (timeout_i != '0) && (timer != TMR_MAX)) begin
      timer <= timer + TMO_W'(1);
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^timeout_i;
  assign tmo_fire       = 1'b0;
`endif

  always_comb begin
    take      = pulse_i & enable_i;
    thr       = (threshold_i == '0) ? CNT_ONE : threshold_i;
    sat       = (count_o == CNT_MAX);
    count_inc = (take && !sat) ? count_o + CNT_ONE : count_o;
    ovf_inc   = overflow_o | (take & sat);

    state_nxt = state;
    count_nxt = count_o;
    irq_nxt   = irq_o;
    ovf_nxt   = overflow_o;

    case (state)
      ST_IDLE: begin
        if (take) begin
          count_nxt = CNT_ONE;
          if (thr == CNT_ONE) begin
            state_nxt = ST_IRQ;
            irq_nxt   = 1'b1;
          end else begin
            state_nxt = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        count_nxt = count_inc;
        ovf_nxt   = ovf_inc;
        // Compared without a pulse too, so a lowered threshold fires at once.
        if ((count_inc >= thr) || tmo_fire) begin
          state_nxt = ST_IRQ;
          irq_nxt   = 1'b1;
        end
      end
      ST_IRQ: begin
        if (ack_i) begin
          ovf_nxt = 1'b0;
          if (take) begin
            count_nxt = CNT_ONE;
            if (thr == CNT_ONE) begin
              state_nxt = ST_IRQ;
              irq_nxt   = 1'b1;
            end else begin
              state_nxt = ST_ACCUM;
              irq_nxt   = 1'b0;
            end
          end else begin
            count_nxt = '0;
            state_nxt = ST_IDLE;
            irq_nxt   = 1'b0;
          end
        end else begin
          count_nxt = count_inc;
          ovf_nxt   = ovf_inc;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = '0;
        irq_nxt   = 1'b0;
        ovf_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      count_o    <= '0;
      irq_o      <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      count_o    <= count_nxt;
      irq_o      <= irq_nxt;
      overflow_o <= ovf_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pulse_event_coalescer.sv
// ============================================================================
// tb_pulse_event_coalescer : directed and randomized bench with a batch-level
// reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pulse_event_coalescer;

  localparam int CNT_W = 4;
  localparam int TMO_W = 16;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_i;
  logic             enable_i;
  logic             pulse_i;
  logic [CNT_W-1:0] threshold_i;
  logic [TMO_W-1:0] timeout_i;
  logic             ack_i;
  logic             irq_o;
  logic [CNT_W-1:0] count_o;
  logic             overflow_o;

  int checks   = 0;
  int failures = 0;

  // Reference: total events in the batch (unbounded), interrupt flag, enabled cycles since first event.
  int total   = 0;
  bit m_irq   = 0;
  int elapsed = 0;

  pulse_event_coalescer #(.CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .enable_i   (enable_i),
    .pulse_i    (pulse_i),
    .threshold_i(threshold_i),
    .timeout_i  (timeout_i),
    .ack_i      (ack_i),
    .irq_o      (irq_o),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int capped(int t);
    return (t > MAXC) ? MAXC : t;
  endfunction

  function automatic void model_reset();
    total   = 0;
    m_irq   = 0;
    elapsed = 0;
  endfunction

  function automatic void model_step(bit p, bit e, bit a, int thr_raw, int tmo);
    int thr;
    bit take;
    bit fire;
    thr  = (thr_raw == 0) ? 1 : thr_raw;
    take = p & e;
    fire = 0;
    if (m_irq) begin
      if (a) begin
        total   = take ? 1 : 0;
        m_irq   = take && (thr == 1);
        elapsed = 0;
      end else begin
        total += int'(take);
      end
    end else if (total == 0) begin
      if (take) begin
        total   = 1;
        m_irq   = (thr == 1);
        elapsed = 0;
      end
    end else begin
`ifdef PULSE_EVENT_COALESCER_TIMEOUT_EN
      if (e && tmo != 0) begin
        elapsed++;
        fire = (elapsed >= tmo);
      end
`else
      fire = (tmo < 0);
`endif
      total += int'(take);
      if (capped(total) >= thr || fire) begin
        m_irq   = 1;
        elapsed = 0;
      end
    end
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    check({tag, "_irq"}, 32'(irq_o), 32'(m_irq));
    check({tag, "_count"}, 32'(count_o), 32'(capped(total)));
    check({tag, "_ovf"}, 32'(overflow_o), 32'(total > MAXC));
  endtask

  task automatic cyc(string tag, bit p, bit e, bit a);
    pulse_i  = p;
    enable_i = e;
    ack_i    = a;
    @(posedge clk);
    model_step(p, e, a, int'(threshold_i), int'(timeout_i));
    #1;
    check_model(tag);
    pulse_i = 1'b0;
    ack_i   = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    enable_i    = 1'b0;
    pulse_i     = 1'b0;
    ack_i       = 1'b0;
    threshold_i = '0;
    timeout_i   = '0;
    #12;
    check("reset_irq", 32'(irq_o), 32'd0);
    check("reset_count", 32'(count_o), 32'd0);
    check("reset_ovf", 32'(overflow_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    // Asynchronous reset in the middle of a batch.
    threshold_i = 4'd4;
    cyc("mid_p1", 1, 1, 0);
    cyc("mid_p2", 1, 1, 0);
    check("mid_count_pre", 32'(count_o), 32'd2);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_count", 32'(count_o), 32'd0);
    check("async_rst_irq", 32'(irq_o), 32'd0);
    check("async_rst_ovf", 32'(overflow_o), 32'd0);
    model_reset();
    @(negedge clk);
    rst_i = 1'b0;

    // Threshold of three with gaps between pulses.
    threshold_i = 4'd3;
    cyc("thr_a", 1, 1, 0);
    check("thr_cnt1", 32'(count_o), 32'd1);
    cyc("thr_b", 0, 1, 0);
    cyc("thr_c", 1, 1, 0);
    check("thr_cnt2", 32'(count_o), 32'd2);
    cyc("thr_d", 0, 1, 0);
    cyc("thr_e", 0, 1, 0);
    cyc("thr_f", 1, 1, 0);
    check("thr_hit_irq", 32'(irq_o), 32'd1);
    check("thr_hit_cnt", 32'(count_o), 32'd3);
    cyc("thr_g", 1, 1, 0);
    cyc("thr_h", 1, 1, 0);
    check("thr_total5", 32'(count_o), 32'd5);
    check("thr_irq_held", 32'(irq_o), 32'd1);
    cyc("thr_ack", 0, 1, 1);
    check("thr_ack_cnt", 32'(count_o), 32'd0);
    check("thr_ack_irq", 32'(irq_o), 32'd0);

    // Zero threshold acts as one; ack collides with a new pulse.
    threshold_i = 4'd0;
    cyc("thr0_p", 1, 1, 0);
    check("thr0_irq", 32'(irq_o), 32'd1);
    cyc("thr0_ackp", 1, 1, 1);
    check("thr0_coll_irq", 32'(irq_o), 32'd1);
    check("thr0_coll_cnt", 32'(count_o), 32'd1);
    cyc("thr0_ack", 0, 1, 1);

    // Saturation at 15 with sticky overflow.
    threshold_i = 4'd15;
    for (int i = 0; i < 17; i++) cyc("sat_p", 1, 1, 0);
    check("sat_cnt", 32'(count_o), 32'd15);
    check("sat_irq", 32'(irq_o), 32'd1);
    check("sat_ovf", 32'(overflow_o), 32'd1);
    cyc("sat_ack", 0, 1, 1);
    check("sat_ack_ovf", 32'(overflow_o), 32'd0);

    // Enable gating and ack ignored outside IRQ.
    for (int i = 0; i < 5; i++) cyc("gate_p", 1, 0, 0);
    check("gate_cnt", 32'(count_o), 32'd0);
    cyc("gate_ack", 0, 1, 1);
    check("gate_ack_irq", 32'(irq_o), 32'd0);

    // Timeout scenario; without the feature the batch waits indefinitely.
    threshold_i = 4'd12;
    timeout_i   = 16'd8;
    cyc("tmo_first", 1, 1, 0);
    for (int i = 0; i < 7; i++) cyc("tmo_wait", 0, 1, 0);
    check("tmo_pre_irq", 32'(irq_o), 32'd0);
    cyc("tmo_edge", 0, 1, 0);
`ifdef PULSE_EVENT_COALESCER_TIMEOUT_EN
    check("tmo_fire_irq", 32'(irq_o), 32'd1);
    check("tmo_fire_cnt", 32'(count_o), 32'd1);
`else
    check("tmo_ignored_irq", 32'(irq_o), 32'd0);
`endif
    cyc("tmo_ack", 0, 1, 1);
    @(negedge clk);
    rst_i = 1'b1;
    model_reset();
    @(negedge clk);
    rst_i = 1'b0;
    timeout_i = 16'd0;
    cyc("tmo0_first", 1, 1, 0);
    for (int i = 0; i < 1000; i++) cyc("tmo0_wait", 0, 1, 0);
    check("tmo0_irq", 32'(irq_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    model_reset();
    @(negedge clk);
    rst_i = 1'b0;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) threshold_i = CNT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 29) == 0) timeout_i = TMO_W'($urandom_range(0, 10));
      cyc("rand", $urandom_range(0, 1) == 1, $urandom_range(0, 6) != 0,
          $urandom_range(0, 6) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
